// File: rtl/microgreen_class_filter.sv
// microgreen_class_filter: sliding-window majority vote over BNN classes,
// with tie hysteresis, a confidence flag and a harvest run-length alert.
module microgreen_class_filter #(
    parameter int         WINDOW        = 8,
    parameter int         THRESH        = 5,
    parameter logic [2:0] HARVEST_CLASS = 3'd2,
    parameter int         HOLD          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  class_in,
    input  logic                        class_valid,
    input  logic                        clear,
    output logic [2:0]                  out_class,
    output logic                        out_valid,
    output logic                        stable,
    output logic                        harvest_alert,
    output logic [$clog2(WINDOW+1)-1:0] fill_count
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int RW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] WIN_C  = CW'(WINDOW);
    localparam logic [CW-1:0] THR_C  = CW'(THRESH);
    localparam logic [RW-1:0] HOLD_C = RW'(HOLD);

    logic [2:0]    hist [WINDOW];
    logic [CW-1:0] cnt  [8];
    logic [RW-1:0] run;
    logic          pend;
    logic          flush;
    logic          full;
    logic [2:0]    oldest;
    logic [CW-1:0] max_cnt;
    logic [2:0]    pick;

    assign flush  = rst | clear;
    assign full   = (fill_count == WIN_C);
    assign oldest = hist[WINDOW-1];

    // Majority search: keep current class on a tie, else lowest index at max
    always_comb begin
        max_cnt = '0;
        for (int c = 0; c < 8; c++) begin
            if (cnt[c] > max_cnt) max_cnt = cnt[c];
        end
        pick = out_class;
        if (cnt[out_class] != max_cnt) begin
            pick = '0;
            for (int c = 7; c >= 0; c--) begin
                if (cnt[c] == max_cnt) pick = 3'(c);
            end
        end
    end

    // Accept stage: history shift, vote counters, run length and fill level
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
            for (int c = 0; c < 8; c++) cnt[c] <= '0;
            run        <= '0;
            fill_count <= '0;
            pend       <= 1'b0;
        end else begin
            pend <= class_valid;
            if (class_valid) begin
                hist[0] <= class_in;
                for (int i = 1; i < WINDOW; i++) hist[i] <= hist[i-1];
                for (int c = 0; c < 8; c++) begin
                    if (class_in == 3'(c) && !(full && oldest == 3'(c)))
                        cnt[c] <= cnt[c] + 1'b1;
                    else if (class_in != 3'(c) && full && oldest == 3'(c))
                        cnt[c] <= cnt[c] - 1'b1;
                end
                if (!full) fill_count <= fill_count + 1'b1;
                if (class_in == HARVEST_CLASS) begin
                    if (run != HOLD_C) run <= run + 1'b1;
                end else begin
                    run <= '0;
                end
            end
        end
    end

    // Decide stage: register outputs one edge after each accepted sample
    always_ff @(posedge clk) begin
        if (flush) begin
            out_class     <= '0;
            out_valid     <= 1'b0;
            stable        <= 1'b0;
            harvest_alert <= 1'b0;
        end else begin
            out_valid <= pend;
            if (pend) begin
                out_class     <= pick;
                stable        <= (max_cnt >= THR_C);
                harvest_alert <= (run == HOLD_C);
            end
        end
    end
endmodule

// File: tb/tb_microgreen_class_filter.sv
// Bench for microgreen_class_filter: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_microgreen_class_filter;
    localparam int         WINDOW = 8;
    localparam int         THRESH = 5;
    localparam int         HOLD   = 4;
    localparam logic [2:0] HC     = 3'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       class_valid = 1'b0;
    logic [2:0] class_in = 3'd0;
    logic [2:0] out_class;
    logic       out_valid;
    logic       stable;
    logic       harvest_alert;
    logic [3:0] fill_count;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int p0;
    bit armed = 0;
    bit alert_seen = 0;

    int q[$];
    int run_m = 0;
    bit pend_m = 0;
    int m_class = 0;
    bit m_valid = 0;
    bit m_stable = 0;
    bit m_alert = 0;
    int mc[8];
    int mx;

    always #5 clk = ~clk;

    microgreen_class_filter #(
        .WINDOW(WINDOW), .THRESH(THRESH),
        .HARVEST_CLASS(HC), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .class_in(class_in),
        .class_valid(class_valid), .clear(clear),
        .out_class(out_class), .out_valid(out_valid),
        .stable(stable), .harvest_alert(harvest_alert),
        .fill_count(fill_count)
    );

    // Reference: history as a queue, votes recounted from scratch
    always @(posedge clk) begin
        if (rst || clear) begin
            q.delete();
            run_m = 0; pend_m = 0; m_class = 0;
            m_valid = 0; m_stable = 0; m_alert = 0;
        end else begin
            m_valid = pend_m;
            if (pend_m) begin
                foreach (mc[c]) mc[c] = 0;
                foreach (q[i]) mc[q[i]]++;
                mx = 0;
                foreach (mc[c]) if (mc[c] > mx) mx = mc[c];
                if (mc[m_class] != mx) begin
                    m_class = 0;
                    while (mc[m_class] != mx) m_class++;
                end
                m_stable = (mx >= THRESH);
                m_alert  = (run_m == HOLD);
            end
            pend_m = class_valid;
            if (class_valid) begin
                q.push_back(int'(class_in));
                if (q.size() > WINDOW) void'(q.pop_front());
                if (class_in == HC) run_m = (run_m < HOLD) ? run_m + 1 : HOLD;
                else run_m = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_class", 32'(out_class), 32'(m_class));
            chk("stable", 32'(stable), 32'(m_stable));
            chk("harvest_alert", 32'(harvest_alert), 32'(m_alert));
            chk("fill_count", 32'(fill_count), 32'(q.size()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) pulses++;
        if (harvest_alert === 1'b1) alert_seen = 1;
    endtask

    task automatic send(input int c);
        class_in = 3'(c);
        class_valid = 1'b1;
        step();
        class_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            class_in = 3'($urandom_range(0, 7));
            step();
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        class_valid = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset(2);
        armed = 1;
        p0 = pulses;
        idle(5);
        chk("rst_pulses", 32'(pulses - p0), 0);
        chk("rst_class", 32'(out_class), 0);
        chk("rst_stable", 32'(stable), 0);
        chk("rst_alert", 32'(harvest_alert), 0);
        chk("rst_fill", 32'(fill_count), 0);

        do_reset(1);
        p0 = pulses;
        repeat (5) send(3);
        idle(1);
        chk("conv_class", 32'(out_class), 3);
        chk("conv_stable", 32'(stable), 1);
        chk("conv_fill", 32'(fill_count), 5);
        chk("conv_pulses", 32'(pulses - p0), 5);

        do_reset(1);
        repeat (8) send(1);
        repeat (4) send(4);
        idle(1);
        chk("evict_tie_class", 32'(out_class), 1);
        chk("evict_tie_stable", 32'(stable), 0);
        chk("evict_tie_fill", 32'(fill_count), 8);
        send(4);
        idle(1);
        chk("evict_class", 32'(out_class), 4);
        chk("evict_stable", 32'(stable), 1);
        chk("evict_fill", 32'(fill_count), 8);

        do_reset(1);
        repeat (4) send(2);
        idle(1);
        chk("harv_rise", 32'(harvest_alert), 1);
        send(0);
        idle(1);
        chk("harv_drop", 32'(harvest_alert), 0);
        alert_seen = 0;
        send(2); send(2); send(2); send(0); send(2);
        idle(1);
        chk("harv_never", 32'(alert_seen), 0);

        do_reset(1);
        repeat (6) send(5);
        idle(1);
        p0 = pulses;
        clear = 1'b1;
        class_in = 3'd5;
        class_valid = 1'b1;
        step();
        clear = 1'b0;
        class_valid = 1'b0;
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_class", 32'(out_class), 0);
        chk("clr_stable", 32'(stable), 0);
        chk("clr_fill", 32'(fill_count), 0);
        idle(1);
        chk("clr_pulses", 32'(pulses - p0), 0);
        send(6);
        idle(1);
        chk("clr_next_class", 32'(out_class), 6);
        chk("clr_next_stable", 32'(stable), 0);
        chk("clr_next_fill", 32'(fill_count), 1);

        do_reset(1);
        idle(1);
        p0 = pulses;
        repeat (3) send(7);
        rst = 1'b1;
        class_in = 3'd7;
        class_valid = 1'b1;
        step();
        rst = 1'b0;
        class_valid = 1'b0;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_fill", 32'(fill_count), 0);
        send(1);
        send(1);
        idle(1);
        chk("mid_pulses", 32'(pulses - p0), 4);
        chk("mid_fill2", 32'(fill_count), 2);
        chk("mid_class", 32'(out_class), 1);

        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 99) == 0);
            class_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) class_in = HC;
            else class_in = 3'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0;
        clear = 1'b0;
        class_valid = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/microgreen_class_filter.md
# microgreen_class_filter

Temporal vote filter placed directly downstream of the microgreen BNN classifier (`tt_um_microgreen_bnn`). It consumes the per-sample 3-bit class and its ready strobe, keeps a sliding window of recent classes, and publishes a debounced majority class with a confidence flag. It also raises a harvest alert once the harvest class has been seen on enough consecutive samples, so single-frame misclassifications never reach the actuator and status logic.

## Interface
- `WINDOW`, 8: history depth; power of two, 2..16.
- `THRESH`, 5: minimum votes for `stable`; 1..WINDOW.
- `HARVEST_CLASS`, 3'd2: class code treated as "harvest".
- `HOLD`, 4: consecutive harvest samples needed for `harvest_alert`; 1..15.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `class_in` in 3: classifier output (`uo_out[2:0]` of the BNN).
- `class_valid` in 1: sample strobe, driven by the BNN ready bit (`uo_out[3]`). Each high cycle is one sample.
- `clear` in 1: synchronous flush, same effect as `rst` on all state.
- `out_class` out 3: current majority class.
- `out_valid` out 1: one-cycle pulse whenever `out_class`, `stable` and `harvest_alert` are refreshed.
- `stable` out 1: majority count >= `THRESH`.
- `harvest_alert` out 1: harvest run length >= `HOLD`.
- `fill_count` out $clog2(WINDOW+1): valid entries in the history, 0..WINDOW.

## Operation
- **History.** Shift register of `WINDOW` x 3 bits, plus per-class vote counters (8 counters, each $clog2(WINDOW+1) bits).
- **Accept (edge A).** On an edge where `class_valid`=1 and `clear`=0:
  - Push `class_in` into the history and increment `count[class_in]`.
  - If `fill_count`==WINDOW, evict the oldest entry and decrement its counter. If the evicted class equals `class_in`, its count is unchanged. Otherwise `fill_count` increments.
  - Counters never exceed WINDOW or go below 0.
- **Harvest run counter.**
  - If `class_in`==HARVEST_CLASS, it increments, saturating at HOLD.
  - Otherwise it resets to 0.
- **Decide (edge A+1).** Registered outputs update from the post-accept counters:
  - Find max = the largest count.
  - If the current `out_class` has count == max, keep it (tie hysteresis). Otherwise pick the lowest class index whose count == max.
  - `stable` = (max >= THRESH).
  - `harvest_alert` = (run == HOLD).
  - `out_valid` = 1 for exactly this cycle.
- **No sample.** With no sample accepted, outputs hold and `out_valid`=0.
- **Back-to-back samples.** `class_valid` may be high every cycle. Each sample produces its own `out_valid` pulse one edge later, so pulses are contiguous.
- **Reset / clear.**
  - Effect: history, counters, run counter and `fill_count` go to 0; `out_class`=0, `out_valid`=0, `stable`=0, `harvest_alert`=0.
  - Priority: `rst`/`clear` beat a simultaneous `class_valid`, and that sample is dropped.
  - Pending decision: a decision pending from the previous edge is also cancelled, so no `out_valid` follows.
- **Undefined input.** `class_in` is ignored when `class_valid`=0.

## Timing
- `class_valid` high in cycle t → counters updated at end of t. Outputs and `out_valid` are visible throughout cycle t+1. Latency is 2 edges from input presentation to output registered.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: every output is 0.
- Throughput: 1 sample/cycle; no backpressure. The BNN ready is assumed to pulse at most once per cycle.
- Wrap-around: eviction is exact at `fill_count`==WINDOW. The (WINDOW+1)th sample evicts sample 1.

## Test plan
- **Reset/defaults.** Assert `rst` 2 cycles, then idle 5 cycles → all outputs 0, `out_valid` never pulses.
- **Convergence.** 5 consecutive samples of class 3 with `class_valid` every cycle → `out_class`=3 from the first pulse. `stable` rises with the 5th decision. `fill_count`=5. 5 `out_valid` pulses, contiguous.
- **Window eviction.**
  - Stimulus: 8×class 1, then 5×class 4.
  - Required: after sample 12, count[1]=4 and count[4]=4 (tie), so `out_class` stays 1 (hysteresis).
  - Required: after sample 13, count[4]=5, so `out_class`=4 and `stable`=1.
  - Required: `fill_count` stays 8.
- **Harvest alert.** Samples 2,2,2,2 → `harvest_alert` rises on the 4th decision. Next sample 0 → alert drops on that decision. Samples 2,2,2,0,2 → alert never asserts.
- **Clear collision.** Fill with 6×class 5, then `clear` and `class_valid`(class 5) high in the same cycle → next cycle all outputs 0, `fill_count`=0, no `out_valid`. A following single class 6 sample → `out_class`=6, `stable`=0.
- **Mid-stream reset.** Assert `rst` for 1 cycle inside a back-to-back burst → the pulse for the sample accepted just before reset is suppressed. Post-reset samples rebuild the window from empty.
